// File: rtl/timed_multiplier.sv
// timed_multiplier: 4x4 unsigned shift-add multiplier sequenced by Johnson timing phases T0..T7.
module timed_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       T0,
  input  logic       T1,
  input  logic       T2,
  input  logic       T3,
  input  logic       T4,
  input  logic       T5,
  input  logic       T6,
  input  logic       T7,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_m, r_q;
  logic [4:0] r_acc;
  logic [7:0] r_p;
  logic       r_err;
  logic [7:0] w_t;
  logic       w_load, w_fault, w_step, w_fin;
  logic [4:0] w_sum;
  assign w_t     = {T7, T6, T5, T4, T3, T2, T1, T0};
  assign w_load  = (r_state == ARMED) && (w_t == 8'h01);
  // Only T1..T5 are legal while running; anything else or a multi-hot phase aborts.
  assign w_fault = (r_state == RUN) && (!$onehot(w_t) || T0 || T6 || T7);
  assign w_step  = (r_state == RUN) && !w_fault && (T1 || T2 || T3 || T4);
  assign w_fin   = (r_state == RUN) && !w_fault && T5;
  assign w_sum   = r_q[0] ? r_acc + {1'b0, r_m} : r_acc;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (start ? ARMED : IDLE) :
             (r_state == ARMED) ? (w_load ? RUN : ARMED) :
             (r_state == RUN)   ? (w_fault ? IDLE : (T5 ? DONE : RUN)) :
             IDLE;
  end
  always_comb begin
    busy = (r_state == ARMED) || (r_state == RUN);
    done = (r_state == DONE);
    P    = r_p;
    err  = r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_m   <= A;
        r_q   <= B;
        r_acc <= '0;
      end else if (w_step) begin
        r_acc <= {1'b0, w_sum[4:1]};
        r_q   <= {w_sum[0], r_q[3:1]};
      end
      if (w_fin)   r_p   <= {r_acc[3:0], r_q};
      if (w_fault) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_timed_multiplier.sv
// tb_timed_multiplier: directed checks of timed_multiplier against hand-computed products.
module tb_timed_multiplier;
  logic       clk = 1'b0;
  logic       rst, start;
  logic       T0, T1, T2, T3, T4, T5, T6, T7;
  logic [3:0] A, B;
  logic [7:0] P;
  logic       busy, done, err;
  int         n_chk = 0;
  int         n_err = 0;
  timed_multiplier dut (
    .clk(clk), .rst(rst), .start(start),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
    .A(A), .B(B), .P(P), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic [7:0] t);
    {T7, T6, T5, T4, T3, T2, T1, T0} = t;
    @(posedge clk);
    #1;
  endtask
  // a_t0 is what A holds at the T0 edge; a_late/B flip after T0 must not matter.
  task automatic mul(input logic [3:0] a_start, input logic [3:0] a_t0, input logic [3:0] b,
                     input logic [3:0] a_late, input bit restart, input logic [7:0] exp,
                     input logic exp_err);
    A = a_start; B = b; start = 1'b1;
    tick(8'h40);
    check("armed_busy", {7'b0, busy}, 8'h01);
    start = 1'b0; A = a_t0;
    tick(8'h80);
    tick(8'h03);
    check("armed_multihot_ignored", {7'b0, busy}, 8'h01);
    tick(8'h01);
    check("run_busy", {6'b0, busy, done}, 8'h02);
    A = a_late; B = ~b;
    tick(8'h02);
    start = restart;
    tick(8'h04);
    start = 1'b0;
    tick(8'h08);
    tick(8'h10);
    check("pre_done_low", {7'b0, done}, 8'h00);
    tick(8'h20);
    check("done_pulse", {6'b0, busy, done}, 8'h01);
    check("product", P, exp);
    check("err_flag", {7'b0, err}, {7'b0, exp_err});
    tick(8'h40);
    check("after_done_idle", {6'b0, busy, done}, 8'h00);
    tick(8'h80);
    check("no_queued_start", {6'b0, busy, done}, 8'h00);
  endtask
  task automatic fault_run(input logic [7:0] bad, input logic [7:0] p_prev);
    A = 4'h9; B = 4'h9; start = 1'b1;
    tick(8'h40);
    start = 1'b0;
    tick(8'h80);
    tick(8'h01);
    tick(8'h02);
    tick(bad);
    check("fault_err", {5'b0, err, busy, done}, 8'h04);
    check("fault_p_kept", P, p_prev);
    tick(8'h10);
    tick(8'h20);
    tick(8'h40);
    check("fault_no_done", {5'b0, err, busy, done}, 8'h04);
    check("fault_p_still", P, p_prev);
  endtask
  initial begin
    rst = 1'b1; start = 1'b1; A = 4'hF; B = 4'hF;
    tick(8'hFF);
    tick(8'h01);
    check("rst_p", P, 8'h00);
    check("rst_flags", {5'b0, err, busy, done}, 8'h00);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) tick(8'h01 << i);
    check("idle_p", P, 8'h00);
    check("idle_flags", {5'b0, err, busy, done}, 8'h00);
    mul(4'd13, 4'd13, 4'd11, 4'd13, 1'b0, 8'h8F, 1'b0);
    mul(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0);
    mul(4'd0, 4'd0, 4'd9, 4'd0, 1'b0, 8'h00, 1'b0);
    mul(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 8'h01, 1'b0);
    mul(4'd3, 4'd7, 4'd2, 4'd7, 1'b0, 8'h0E, 1'b0);
    mul(4'd5, 4'd5, 4'd2, 4'd9, 1'b0, 8'h0A, 1'b0);
    mul(4'd4, 4'd4, 4'd3, 4'd4, 1'b1, 8'h0C, 1'b0);
    mul(4'd6, 4'd6, 4'd7, 4'd6, 1'b0, 8'h2A, 1'b0);
    fault_run(8'h0C, 8'h2A);
    mul(4'd2, 4'd2, 4'd3, 4'd2, 1'b0, 8'h06, 1'b1);
    fault_run(8'h01, 8'h06);
    check("err_sticky", {7'b0, err}, 8'h01);
    A = 4'hA; B = 4'hB; start = 1'b1;
    tick(8'h40);
    start = 1'b0;
    tick(8'h80);
    tick(8'h01);
    tick(8'h02);
    tick(8'h04);
    rst = 1'b1;
    tick(8'h08);
    rst = 1'b0;
    check("midrun_rst_p", P, 8'h00);
    check("midrun_rst_flags", {5'b0, err, busy, done}, 8'h00);
    tick(8'h10);
    tick(8'h20);
    tick(8'h40);
    check("midrun_rst_no_done", {5'b0, err, busy, done}, 8'h00);
    mul(4'd6, 4'd6, 4'd5, 4'd6, 1'b0, 8'h1E, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/timed_multiplier.md
TIMED_MULTIPLIER -- requirements
Module: timed_multiplier

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock; all state updates on posedge clk).
REQ-002 SHALL have ports: rst input 1 (synchronous, active-high reset; sampled on posedge clk).
REQ-003 SHALL have ports: start input 1 (request one multiplication; sampled only in IDLE).
REQ-004 SHALL have ports: T0..T7 input 1 each (one-hot timing phases from the 8-state Johnson timing generator; one phase per clk).
REQ-005 SHALL have ports: A input 4 (multiplicand, unsigned).
REQ-006 SHALL have ports: B input 4 (multiplier, unsigned).
REQ-007 SHALL have ports: P output 8 (registered product; holds until next capture).
REQ-008 SHALL have ports: busy output 1 (high in ARMED and RUN).
REQ-009 SHALL have ports: done output 1 (one-cycle pulse, product valid).
REQ-010 SHALL have ports: err output 1 (sticky timing-fault flag).

Function
REQ-011 SHALL implement FSM states IDLE, ARMED, RUN, DONE.
REQ-012 IDLE: start=1 -> ARMED; otherwise stay.
REQ-013 ARMED: wait for T0=1; in that cycle load M<=A, Q<=B, ACC<=0 (5-bit incl. carry), go to RUN.
REQ-014 A and B SHALL be sampled only at the T0 load edge; changes at other times have no effect.
REQ-015 RUN, phases T1..T4: one shift-add step per phase: if Q[0]=1 then ACC<=ACC+M (5-bit, no overflow loss); then {ACC,Q} shifted right by 1, zero into MSB.
REQ-016 RUN, phase T5: P<={ACC[3:0],Q}; go to DONE.
REQ-017 DONE: done=1 for exactly this one cycle; go to IDLE; T6/T7 carry no operation.
REQ-018 Latency SHALL be: T0 load edge to done high = 6 clk cycles; product is exact for all 256 input pairs.
REQ-019 start while busy or in DONE SHALL be ignored (not queued).
REQ-020 In RUN, any cycle where the count of asserted T0..T7 is not exactly one, or T0/T6/T7 is seen before T5, SHALL set err=1, abort to IDLE, and leave P unchanged.
REQ-021 err SHALL remain 1 until rst; a new start is still accepted while err=1.
REQ-022 ARMED SHALL ignore T1..T7 and multi-hot phases; only a clean one-hot T0 arms.
REQ-023 busy SHALL deassert in the same edge that enters DONE; done and busy are never both 1.

Reset
REQ-024 rst=1 at a posedge SHALL force state=IDLE, P=0x00, ACC=0, Q=0, M=0, busy=0, done=0, err=0, overriding start and all T inputs.
REQ-025 rst asserted mid-RUN SHALL discard the operation with no done pulse; the first start after release begins a fresh sequence.
REQ-026 Outputs after reset release SHALL remain at reset values until a start is accepted.

Verification
REQ-027 A=13, B=11, start pulse, Johnson phases cycling -> done one cycle after the T5 edge, P=0x8F, busy low.
REQ-028 A=15, B=15 -> P=0xE1; A=0, B=9 -> P=0x00; A=1, B=1 -> P=0x01 (carry and boundary check).
REQ-029 A changed from 3 to 7 between start and T0, B=2 -> P=0x0E; A changed after T0 -> P unchanged by the change.
REQ-030 Second start pulse during RUN -> ignored; exactly one done; next start after IDLE is accepted normally.
REQ-031 T2 and T3 both high in RUN -> err=1, state IDLE, P keeps previous value, no done; err stays 1 until rst.
REQ-032 rst pulsed at T3 of a run -> all outputs 0 next cycle, no done; a subsequent run with A=6, B=5 -> P=0x1E.
